pong_game_ctrl: RTL and testbench

Game sequencer for the pong datapath. It owns the match state (idle, serve, play, game over) and the two 4-bit scores. It drives ball_logic via run/serve controls and consumes miss pulses from the collision logic. It sits between the frame timing generator and the ball/paddle logic.

---
 rtl/pong_game_ctrl.sv | 139 +++++++++++++
 tb/tb_pong_game_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: IDLE -> SERVE -> PLAY -> OVER.
// Owns both scores and drives ball_logic run/serve controls.
module pong_game_ctrl #(
    parameter int SCORE_MAX   = 9,
    parameter int SERVE_DELAY = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic       ball_run,
    output logic       ball_serve,
    output logic       serve_dir,
    output logic [3:0] score_left,
    output logic [3:0] score_right,
    output logic [1:0] state,
    output logic       game_over,
    output logic       winner
);

    localparam logic [3:0] SMAX = 4'(SCORE_MAX);
    localparam logic [7:0] SDLY = 8'(SERVE_DELAY);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        PLAY  = 2'd2,
        OVER  = 2'd3
    } state_t;

    state_t     st;
    logic [7:0] cnt;
    logic       start_q;

    logic       start_rise;
    logic       replay;
    logic       pt_left;
    logic       pt_right;
    logic [3:0] inc_left;
    logic [3:0] inc_right;

    // miss_left means the right player scores and vice versa
    assign start_rise = start & ~start_q;
    assign replay     = miss_left & miss_right;
    assign pt_right   = miss_left & ~miss_right;
    assign pt_left    = miss_right & ~miss_left;
    assign inc_left   = score_left + 4'd1;
    assign inc_right  = score_right + 4'd1;

    assign state = st;

    // Match FSM with all outputs registered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st          <= IDLE;
            cnt         <= 8'd0;
            start_q     <= 1'b0;
            score_left  <= 4'd0;
            score_right <= 4'd0;
            serve_dir   <= 1'b1;
            winner      <= 1'b0;
            ball_run    <= 1'b0;
            ball_serve  <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            start_q    <= start;
            ball_serve <= 1'b0;
            unique case (st)
                IDLE, OVER: begin
                    if (start_rise) begin
                        score_left  <= 4'd0;
                        score_right <= 4'd0;
                        serve_dir   <= 1'b1;
                        cnt         <= SDLY;
                        st          <= SERVE;
                        ball_serve  <= 1'b1;
                        ball_run    <= 1'b0;
                        game_over   <= 1'b0;
                    end
                end
                SERVE: begin
                    if (frame_tick) begin
                        if (cnt == 8'd1) begin
                            st       <= PLAY;
                            ball_run <= 1'b1;
                        end else begin
                            cnt <= cnt - 8'd1;
                        end
                    end
                end
                PLAY: begin
                    unique case (1'b1)
                        replay: begin
                            cnt        <= SDLY;
                            st         <= SERVE;
                            ball_serve <= 1'b1;
                            ball_run   <= 1'b0;
                        end
                        pt_right: begin
                            score_right <= inc_right;
                            serve_dir   <= 1'b0;
                            ball_run    <= 1'b0;
                            if (inc_right == SMAX) begin
                                st        <= OVER;
                                winner    <= 1'b1;
                                game_over <= 1'b1;
                            end else begin
                                cnt        <= SDLY;
                                st         <= SERVE;
                                ball_serve <= 1'b1;
                            end
                        end
                        pt_left: begin
                            score_left <= inc_left;
                            serve_dir  <= 1'b1;
                            ball_run   <= 1'b0;
                            if (inc_left == SMAX) begin
                                st        <= OVER;
                                winner    <= 1'b0;
                                game_over <= 1'b1;
                            end else begin
                                cnt        <= SDLY;
                                st         <= SERVE;
                                ball_serve <= 1'b1;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed vector bench for pong_game_ctrl.
// Uses SCORE_MAX=3, SERVE_DELAY=2.
module tb_pong_game_ctrl;

    logic       clk;
    logic       reset;
    logic       frame_tick;
    logic       start;
    logic       miss_left;
    logic       miss_right;
    logic       ball_run;
    logic       ball_serve;
    logic       serve_dir;
    logic [3:0] score_left;
    logic [3:0] score_right;
    logic [1:0] state;
    logic       game_over;
    logic       winner;

    int total = 0;
    int bad   = 0;

    pong_game_ctrl #(
        .SCORE_MAX(3),
        .SERVE_DELAY(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .frame_tick(frame_tick),
        .start(start),
        .miss_left(miss_left),
        .miss_right(miss_right),
        .ball_run(ball_run),
        .ball_serve(ball_serve),
        .serve_dir(serve_dir),
        .score_left(score_left),
        .score_right(score_right),
        .state(state),
        .game_over(game_over),
        .winner(winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       s;
        logic       f;
        logic       ml;
        logic       mr;
        logic [1:0] st;
        logic       run;
        logic       srv;
        logic       dir;
        logic [3:0] sl;
        logic [3:0] sr;
        logic       ov;
        logic       win;
    } vec_t;

    vec_t ta[27];
    vec_t tb[12];

    function automatic vec_t mk(input bit s, input bit f, input bit ml,
                                input bit mr, input int st, input bit run,
                                input bit srv, input bit dir, input int sl,
                                input int sr, input bit ov, input bit win);
        vec_t v;
        v.s   = s;
        v.f   = f;
        v.ml  = ml;
        v.mr  = mr;
        v.st  = 2'(st);
        v.run = run;
        v.srv = srv;
        v.dir = dir;
        v.sl  = 4'(sl);
        v.sr  = 4'(sr);
        v.ov  = ov;
        v.win = win;
        return v;
    endfunction

    // winner is only checked when the expected state is OVER
    task automatic check(input string name, input vec_t e);
        logic [14:0] act;
        logic [14:0] req;
        logic        w;
        w   = (e.st == 2'd3) ? winner : e.win;
        act = {state, ball_run, ball_serve, serve_dir,
               score_left, score_right, game_over, w};
        req = {e.st, e.run, e.srv, e.dir, e.sl, e.sr, e.ov, e.win};
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got st=%0d run=%b srv=%b dir=%b sl=%0d sr=%0d ov=%b win=%b want st=%0d run=%b srv=%b dir=%b sl=%0d sr=%0d ov=%b win=%b",
                     name, state, ball_run, ball_serve, serve_dir,
                     score_left, score_right, game_over, w,
                     e.st, e.run, e.srv, e.dir, e.sl, e.sr, e.ov, e.win);
        end
    endtask

    task automatic apply(input string name, input vec_t v);
        start      = v.s;
        frame_tick = v.f;
        miss_left  = v.ml;
        miss_right = v.mr;
        @(posedge clk);
        #1;
        check(name, v);
    endtask

    initial begin
        // s f ml mr | st run srv dir sl sr ov win
        ta[0]  = mk(1, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0);
        ta[1]  = mk(1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        ta[2]  = mk(1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        ta[3]  = mk(1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        ta[4]  = mk(1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        ta[5]  = mk(0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        ta[6]  = mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        ta[7]  = mk(0, 1, 0, 0, 2, 1, 0, 1, 0, 0, 0, 0);
        ta[8]  = mk(0, 0, 1, 0, 1, 0, 1, 0, 0, 1, 0, 0);
        ta[9]  = mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
        ta[10] = mk(0, 1, 0, 0, 2, 1, 0, 0, 0, 1, 0, 0);
        ta[11] = mk(0, 0, 1, 1, 1, 0, 1, 0, 0, 1, 0, 0);
        ta[12] = mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
        ta[13] = mk(0, 1, 0, 0, 2, 1, 0, 0, 0, 1, 0, 0);
        ta[14] = mk(0, 0, 0, 1, 1, 0, 1, 1, 1, 1, 0, 0);
        ta[15] = mk(0, 1, 0, 0, 1, 0, 0, 1, 1, 1, 0, 0);
        ta[16] = mk(0, 1, 0, 0, 2, 1, 0, 1, 1, 1, 0, 0);
        ta[17] = mk(0, 0, 0, 1, 1, 0, 1, 1, 2, 1, 0, 0);
        ta[18] = mk(0, 1, 0, 0, 1, 0, 0, 1, 2, 1, 0, 0);
        ta[19] = mk(0, 1, 0, 0, 2, 1, 0, 1, 2, 1, 0, 0);
        ta[20] = mk(0, 0, 0, 1, 3, 0, 0, 1, 3, 1, 1, 0);
        ta[21] = mk(0, 0, 1, 0, 3, 0, 0, 1, 3, 1, 1, 0);
        ta[22] = mk(0, 0, 0, 1, 3, 0, 0, 1, 3, 1, 1, 0);
        ta[23] = mk(0, 1, 0, 0, 3, 0, 0, 1, 3, 1, 1, 0);
        ta[24] = mk(1, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0);
        ta[25] = mk(1, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        ta[26] = mk(0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0);

        // frame_tick in IDLE ignored, in the serve cycle counted
        tb[0]  = mk(1, 1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0);
        tb[1]  = mk(1, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        tb[2]  = mk(0, 1, 0, 0, 2, 1, 0, 1, 0, 0, 0, 0);
        tb[3]  = mk(0, 0, 1, 0, 1, 0, 1, 0, 0, 1, 0, 0);
        tb[4]  = mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
        tb[5]  = mk(0, 1, 0, 0, 2, 1, 0, 0, 0, 1, 0, 0);
        tb[6]  = mk(0, 0, 1, 0, 1, 0, 1, 0, 0, 2, 0, 0);
        tb[7]  = mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 2, 0, 0);
        tb[8]  = mk(0, 1, 0, 0, 2, 1, 0, 0, 0, 2, 0, 0);
        tb[9]  = mk(0, 0, 1, 0, 3, 0, 0, 0, 0, 3, 1, 1);
        tb[10] = mk(0, 0, 0, 0, 3, 0, 0, 0, 0, 3, 1, 1);
        tb[11] = mk(1, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0);
    end

    initial begin
        vec_t idle_v;
        idle_v     = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        reset      = 1'b0;
        start      = 1'b0;
        frame_tick = 1'b0;
        miss_left  = 1'b0;
        miss_right = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        check("reset", idle_v);

        for (int i = 0; i < 27; i++)
            apply($sformatf("a%0d", i), ta[i]);

        // SERVE with counter at 1: async reset mid-cycle
        start      = 1'b0;
        frame_tick = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        check("async_rst", idle_v);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_hold", idle_v);
        reset = 1'b1;
        for (int i = 0; i < 3; i++)
            apply($sformatf("idle%0d", i), idle_v);

        for (int i = 0; i < 12; i++)
            apply($sformatf("b%0d", i), tb[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
